// File: rtl/sysarray_credit_gate.sv
// sysarray_credit_gate
// -------------------------------------------------------------------------
// Issue-side credit gate for the SysArray kernel datapath. It accepts a
// transaction count from the kernel control FSM and issues that many
// requests over a valid/ready handshake. No more than C_MAX_CREDITS
// requests may be in flight. Each returned response frees one credit.
// After the last request is issued, the block waits for every
// outstanding response, pulses ctrl_done and returns to IDLE.
//
// Handshake semantics (request side): a request transfers on every rising
// edge where req_valid && req_ready. req_valid is decoded from registered
// state only and has no combinational dependency on req_ready or
// rsp_valid. Once it is raised it stays high until the transfer completes.
// Only the transfer itself lowers remaining, and a response can only lower
// outstanding.
//
// Ports:
//   ap_clk         : clock, rising edge
//   ap_rst_n       : asynchronous active-low reset
//   ctrl_start     : single-cycle start pulse, honoured only in IDLE
//   ctrl_num_xfers : number of requests to issue, captured with ctrl_start
//   ctrl_done      : one-cycle pulse after all requests and responses
//   ctrl_idle      : high while in IDLE
//   req_valid      : request offered downstream
//   req_ready      : downstream accepts the request
//   rsp_valid      : one response returned (at most one per cycle)
//   outstanding    : requests currently in flight
//   remaining      : requests not yet issued
//   err_underflow  : sticky, response arrived with nothing in flight
//   dbg_state      : current FSM state, for checkers and debug
// -------------------------------------------------------------------------
module sysarray_credit_gate #(
  parameter int C_XFER_WIDTH  = 16,
  parameter int C_CNT_WIDTH   = 6,
  parameter int C_MAX_CREDITS = 32
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    ctrl_start,
  input  logic [C_XFER_WIDTH-1:0] ctrl_num_xfers,
  output logic                    ctrl_done,
  output logic                    ctrl_idle,
  output logic                    req_valid,
  input  logic                    req_ready,
  input  logic                    rsp_valid,
  output logic [C_CNT_WIDTH-1:0]  outstanding,
  output logic [C_XFER_WIDTH-1:0] remaining,
  output logic                    err_underflow,
  output logic [1:0]              dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [C_CNT_WIDTH-1:0]  CREDIT_MAX = C_CNT_WIDTH'(C_MAX_CREDITS);
  localparam logic [C_XFER_WIDTH-1:0] REM_ONE    = C_XFER_WIDTH'(1);

  logic [1:0]              state_q;
  logic [1:0]              state_nxt;
  logic [C_XFER_WIDTH-1:0] rem_q;
  logic [C_XFER_WIDTH-1:0] rem_nxt;
  logic [C_CNT_WIDTH-1:0]  out_q;
  logic [C_CNT_WIDTH-1:0]  out_nxt;
  logic                    err_q;
  logic                    err_nxt;
  logic                    issue_fire;

  // Request offer is a pure function of registered state. remaining!=0
  // keeps the final handshake from being offered twice; the credit check
  // keeps outstanding at or below C_MAX_CREDITS.
  assign req_valid  = (state_q == S_ISSUE) && (rem_q != '0) && (out_q < CREDIT_MAX);
  assign issue_fire = req_valid && req_ready;

  // In-flight accounting, active in every state. A same-cycle issue and
  // response cancel out. A response with nothing in flight and no issue
  // to cancel against flags underflow and leaves the count at zero.
  always_comb begin
    out_nxt = out_q;
    err_nxt = err_q;
    case ({issue_fire, rsp_valid})
      2'b10: out_nxt = out_q + 1'b1;
      2'b01: begin
        if (out_q == '0) begin
          err_nxt = 1'b1;
        end else begin
          out_nxt = out_q - 1'b1;
        end
      end
      default: out_nxt = out_q;
    endcase
  end

  // Control FSM and remaining-count update.
  always_comb begin
    state_nxt = state_q;
    rem_nxt   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (ctrl_start) begin
          if (ctrl_num_xfers != '0) begin
            rem_nxt   = ctrl_num_xfers;
            state_nxt = S_ISSUE;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        if (issue_fire) begin
          rem_nxt = rem_q - 1'b1;
          if (rem_q == REM_ONE) begin
            state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Looking at the next-state count lets the final response and
        // the move to DONE happen on the same edge.
        if (out_nxt == '0) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      rem_q   <= rem_nxt;
      out_q   <= out_nxt;
      err_q   <= err_nxt;
    end
  end

  assign ctrl_done     = (state_q == S_DONE);
  assign ctrl_idle     = (state_q == S_IDLE);
  assign outstanding   = out_q;
  assign remaining     = rem_q;
  assign err_underflow = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_sysarray_credit_gate.sv
// Bench for sysarray_credit_gate. Two instances are used: inst 0 keeps the
// default 32-credit limit and inst 1 has a 2-credit limit for stall cases.
module tb_sysarray_credit_gate;

  localparam int XW = 16;
  localparam int CW = 6;
  localparam int NI = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [NI-1:0] start_i  = '0;
  logic [NI-1:0] ready_i  = '0;
  logic [NI-1:0] man_rsp  = '0;
  logic [NI-1:0] auto_rsp = '0;
  logic [NI-1:0] hold     = '0;
  logic [NI-1:0] rsp_i;
  logic [XW-1:0] num_i [NI];
  logic [NI-1:0] done_o, idle_o, rv_o, err_o;
  logic [CW-1:0] out_o [NI];
  logic [XW-1:0] rem_o [NI];
  logic [1:0]    st_o  [NI];

  assign rsp_i = auto_rsp | man_rsp;

  sysarray_credit_gate #(.C_XFER_WIDTH(XW), .C_CNT_WIDTH(CW), .C_MAX_CREDITS(32)) dut0 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .ctrl_start(start_i[0]), .ctrl_num_xfers(num_i[0]),
    .ctrl_done(done_o[0]), .ctrl_idle(idle_o[0]),
    .req_valid(rv_o[0]), .req_ready(ready_i[0]), .rsp_valid(rsp_i[0]),
    .outstanding(out_o[0]), .remaining(rem_o[0]),
    .err_underflow(err_o[0]), .dbg_state(st_o[0])
  );

  sysarray_credit_gate #(.C_XFER_WIDTH(XW), .C_CNT_WIDTH(CW), .C_MAX_CREDITS(2)) dut1 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .ctrl_start(start_i[1]), .ctrl_num_xfers(num_i[1]),
    .ctrl_done(done_o[1]), .ctrl_idle(idle_o[1]),
    .req_valid(rv_o[1]), .req_ready(ready_i[1]), .rsp_valid(rsp_i[1]),
    .outstanding(out_o[1]), .remaining(rem_o[1]),
    .err_underflow(err_o[1]), .dbg_state(st_o[1])
  );

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_ISSUE = 1, M_DRAIN = 2, M_DONE = 3;
  int m_st [NI];
  int m_rem [NI];
  int m_out [NI];
  bit m_err [NI];

  function automatic int maxc(input int i);
    return (i == 0) ? 32 : 2;
  endfunction

  function automatic bit m_rv(input int i);
    return (m_st[i] == M_ISSUE) && (m_rem[i] != 0) && (m_out[i] < maxc(i));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit hs;
    bit ne;
    int no;
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        m_st[i]  <= M_IDLE;
        m_rem[i] <= 0;
        m_out[i] <= 0;
        m_err[i] <= 1'b0;
      end else begin
        hs = m_rv(i) && ready_i[i];
        no = m_out[i];
        ne = m_err[i];
        if (hs && !rsp_i[i]) no = no + 1;
        else if (!hs && rsp_i[i]) begin
          if (no == 0) ne = 1'b1;
          else no = no - 1;
        end
        m_out[i] <= no;
        m_err[i] <= ne;
        case (m_st[i])
          M_IDLE: if (start_i[i]) begin
            if (num_i[i] != 0) begin
              m_rem[i] <= int'(num_i[i]);
              m_st[i]  <= M_ISSUE;
            end else begin
              m_st[i] <= M_DONE;
            end
          end
          M_ISSUE: if (hs) begin
            m_rem[i] <= m_rem[i] - 1;
            if (m_rem[i] == 1) m_st[i] <= M_DRAIN;
          end
          M_DRAIN: if (no == 0) m_st[i] <= M_DONE;
          default: m_st[i] <= M_IDLE;
        endcase
      end
    end
  end

  // ---------------- downstream responder ----------------
  int edge_cnt = 0;
  int pend0[$];
  int pend1[$];
  int hs_cnt [NI] = '{0, 0};
  int last_rsp_edge [NI] = '{0, 0};

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (!rst_n) begin
      pend0.delete();
      pend1.delete();
    end else begin
      if (rsp_i[0] && pend0.size() > 0) void'(pend0.pop_front());
      if (rsp_i[1] && pend1.size() > 0) void'(pend1.pop_front());
      if (rv_o[0] && ready_i[0]) begin
        pend0.push_back(edge_cnt + 1);
        hs_cnt[0] <= hs_cnt[0] + 1;
      end
      if (rv_o[1] && ready_i[1]) begin
        pend1.push_back(edge_cnt + 1);
        hs_cnt[1] <= hs_cnt[1] + 1;
      end
      if (rsp_i[0]) last_rsp_edge[0] <= edge_cnt + 1;
      if (rsp_i[1]) last_rsp_edge[1] <= edge_cnt + 1;
    end
  end

  // Each request is answered three edges after it was accepted.
  always @(negedge clk) begin
    auto_rsp[0] <= !hold[0] && (pend0.size() > 0) && (pend0[0] + 3 <= edge_cnt + 1);
    auto_rsp[1] <= !hold[1] && (pend1.size() > 0) && (pend1[0] + 3 <= edge_cnt + 1);
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    string  name;
    int     inst;
    longint act;
    longint exp;
  } lit_t;
  lit_t lit_q[$];

  int errors = 0;
  int checks = 0;
  int peak [NI] = '{0, 0};
  int done_cnt [NI] = '{0, 0};
  int done_edge [NI] = '{0, 0};

  function automatic void lit(input string n, input int i, input longint a, input longint e);
    lit_t c;
    c.name = n; c.inst = i; c.act = a; c.exp = e;
    lit_q.push_back(c);
  endfunction

  task automatic chk(input string n, input int i, input longint a, input longint e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s[inst%0d] @%0t: got %0d expected %0d", n, i, $time, a, e);
    end
  endtask

  // Single compare process: literal expectations and per-cycle model check.
  initial begin
    lit_t c;
    forever begin
      @(negedge clk);
      while (lit_q.size() > 0) begin
        c = lit_q.pop_front();
        chk(c.name, c.inst, c.act, c.exp);
      end
      if (rst_n) begin
        for (int i = 0; i < NI; i++) begin
          chk("req_valid", i, rv_o[i], m_rv(i));
          chk("outstanding", i, out_o[i], m_out[i]);
          chk("remaining", i, rem_o[i], m_rem[i]);
          chk("err_underflow", i, err_o[i], m_err[i]);
          chk("ctrl_idle", i, idle_o[i], m_st[i] == M_IDLE);
          chk("ctrl_done", i, done_o[i], m_st[i] == M_DONE);
          chk("dbg_state_known", i, $isunknown(st_o[i]), 0);
          if (int'(out_o[i]) > peak[i]) peak[i] = int'(out_o[i]);
          if (done_o[i]) begin
            done_cnt[i]  = done_cnt[i] + 1;
            done_edge[i] = edge_cnt;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  int start_e;

  task automatic start_xfer(input int i, input int n);
    @(negedge clk);
    start_i[i] = 1'b1;
    num_i[i]   = XW'(n);
    start_e    = edge_cnt + 1;
    @(negedge clk);
    start_i[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, input int budget);
    int n;
    n = 0;
    while (!idle_o[i] && n < budget) begin
      @(negedge clk);
      n++;
    end
    lit("idle_timeout", i, (n < budget), 1);
  endtask

  task automatic lit_reset_vals(input int i, input string tag);
    lit({tag, "_idle"}, i, idle_o[i], 1);
    lit({tag, "_req_valid"}, i, rv_o[i], 0);
    lit({tag, "_done"}, i, done_o[i], 0);
    lit({tag, "_outstanding"}, i, out_o[i], 0);
    lit({tag, "_remaining"}, i, rem_o[i], 0);
    lit({tag, "_err"}, i, err_o[i], 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base_hs;
    int base_done;
    num_i[0] = '0;
    num_i[1] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    lit_reset_vals(0, "reset");
    lit_reset_vals(1, "reset");

    // Basic run: 4 requests, responses three cycles after each request.
    ready_i[0] = 1'b1;
    base_hs   = hs_cnt[0];
    base_done = done_cnt[0];
    start_xfer(0, 4);
    lit("first_req_latency", 0, rv_o[0], 1);
    wait_idle(0, 50);
    lit("basic_handshakes", 0, hs_cnt[0] - base_hs, 4);
    lit("basic_peak", 0, peak[0], 3);
    lit("basic_done_pulses", 0, done_cnt[0] - base_done, 1);
    lit("basic_done_latency", 0, done_edge[0] - start_e, 7);
    lit("basic_done_after_rsp", 0, done_edge[0] - last_rsp_edge[0], 0);

    // Credit stall on the 2-credit instance, responses withheld.
    hold[1]    = 1'b1;
    ready_i[1] = 1'b1;
    base_hs    = hs_cnt[1];
    base_done  = done_cnt[1];
    start_xfer(1, 5);
    lit("stall_rv_start", 1, rv_o[1], 1);
    lit("stall_rem_start", 1, rem_o[1], 5);
    repeat (2) @(negedge clk);
    lit("stall_rv_drop", 1, rv_o[1], 0);
    lit("stall_out_hold", 1, out_o[1], 2);
    lit("stall_rem_hold", 1, rem_o[1], 3);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      lit("stall_rv_low", 1, rv_o[1], 0);
      lit("stall_out_2", 1, out_o[1], 2);
    end
    man_rsp[1] = 1'b1;
    lit("stall_rv_same_cycle", 1, rv_o[1], 0);
    @(negedge clk);
    lit("stall_rv_reenabled", 1, rv_o[1], 1);
    lit("stall_out_after_rsp", 1, out_o[1], 1);
    lit("stall_rem_before", 1, rem_o[1], 3);
    // Response kept high so it coincides with the next handshake.
    @(negedge clk);
    man_rsp[1] = 1'b0;
    lit("simul_out_unchanged", 1, out_o[1], 1);
    lit("simul_rem_dec", 1, rem_o[1], 2);
    hold[1] = 1'b0;
    wait_idle(1, 100);
    lit("stall_handshakes", 1, hs_cnt[1] - base_hs, 5);
    lit("stall_done_pulses", 1, done_cnt[1] - base_done, 1);

    // Zero-length transfer.
    base_hs   = hs_cnt[0];
    base_done = done_cnt[0];
    start_xfer(0, 0);
    lit("zero_done", 0, done_o[0], 1);
    lit("zero_rv", 0, rv_o[0], 0);
    @(negedge clk);
    lit("zero_done_drop", 0, done_o[0], 0);
    lit("zero_idle", 0, idle_o[0], 1);
    lit("zero_handshakes", 0, hs_cnt[0] - base_hs, 0);
    lit("zero_done_pulses", 0, done_cnt[0] - base_done, 1);

    // Backpressure plus a start pulse that must be ignored.
    ready_i[0] = 1'b0;
    base_hs    = hs_cnt[0];
    base_done  = done_cnt[0];
    start_xfer(0, 3);
    for (int k = 0; k < 5; k++) begin
      lit("bp_rv_held", 0, rv_o[0], 1);
      lit("bp_rem_held", 0, rem_o[0], 3);
      if (k == 1) begin
        start_i[0] = 1'b1;
        num_i[0]   = XW'(9);
      end
      if (k == 2) start_i[0] = 1'b0;
      @(negedge clk);
    end
    ready_i[0] = 1'b1;
    wait_idle(0, 60);
    lit("bp_handshakes", 0, hs_cnt[0] - base_hs, 3);
    lit("bp_done_pulses", 0, done_cnt[0] - base_done, 1);

    // Underflow in IDLE, then asynchronous reset in the middle of ISSUE.
    man_rsp[0] = 1'b1;
    @(negedge clk);
    man_rsp[0] = 1'b0;
    lit("uf_err_set", 0, err_o[0], 1);
    lit("uf_out_zero", 0, out_o[0], 0);
    lit("uf_other_inst", 1, err_o[1], 0);
    @(negedge clk);
    lit("uf_err_sticky", 0, err_o[0], 1);
    hold[0]    = 1'b1;
    ready_i[0] = 1'b1;
    start_xfer(0, 5);
    repeat (2) @(negedge clk);
    ready_i[0] = 1'b0;
    lit("rst_pre_out", 0, out_o[0], 2);
    lit("rst_pre_rem", 0, rem_o[0], 3);
    lit("rst_pre_err", 0, err_o[0], 1);
    #2;
    rst_n = 1'b0;
    #1;
    lit_reset_vals(0, "async_rst");
    lit_reset_vals(1, "async_rst");
    @(negedge clk);
    rst_n   = 1'b1;
    hold[0] = 1'b0;
    repeat (3) @(negedge clk);
    lit("post_rst_idle", 0, idle_o[0], 1);
    lit("post_rst_err", 0, err_o[0], 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
